ap_seq_ctrl: RTL and testbench
==============================

// Module: ap_seq_ctrl
// PURPOSE
//   Sequencer for the HLS park-guidance core (ap_ctrl_hs handshake). Generates periodic or
//   software-requested runs: latches sensor/route operands, drives ap_start until ap_ready,
//   waits for ap_done, and captures next_dirc. Adds watchdog timeout, overrun detection and a run counter.
// PARAMETERS
//   PERIOD   1000  cycles between auto-triggers when enable=1 (>=2)
//   TIMEOUT  4096  max cycles in START+WAIT before abort (>=2)
//   DW       32    operand / result width
// PORTS
//   ap_clk            in   1   clock, all logic rising-edge
//   ap_rst            in   1   asynchronous, active-high reset
//   enable            in   1   1 = periodic auto-trigger active
//   sw_start          in   1   one-cycle software trigger pulse
//   err_clr           in   1   clears timeout_err and overrun_err
//   accel_x_in        in   DW  live accel_x operand
//   yaw_in            in   DW  live yaw operand
//   start_point_in    in   DW  live start_point operand
//   end_point_in      in   DW  live end_point operand
//   acc_start         out  1   ap_start to core
//   acc_done          in   1   ap_done from core
//   acc_idle          in   1   ap_idle from core
//   acc_ready         in   1   ap_ready from core
//   acc_accel_x/acc_yaw/acc_start_point/acc_end_point  out  DW  latched operands to core
//   acc_next_dirc     in   DW  next_dirc from core
//   acc_next_dirc_vld in   1   next_dirc_ap_vld from core
//   dirc_out          out  DW  last captured direction
//   dirc_valid        out  1   one-cycle pulse: dirc_out updated by completed run
//   busy              out  1   1 in any state except IDLE
//   timeout_err       out  1   sticky: watchdog abort occurred
//   overrun_err       out  1   sticky: trigger lost while one already pending
//   run_count         out  16  completed runs, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset: state=IDLE; all outputs, operand regs, pending, period and watchdog counters = 0.
//   Period counter: when enable=1 counts 0..PERIOD-1, tick=1 in cycle count==PERIOD-1, wraps to 0;
//     enable=0 holds counter at 0, no tick. trigger = tick | sw_start.
//   pending flag: set by trigger in any state; cleared on IDLE->LATCH. trigger while pending=1
//     and not consumed that cycle -> overrun_err=1 (trigger dropped). Max one queued run.
//   FSM (all outputs registered, state-decoded):
//     IDLE : (trigger|pending) & acc_idle -> LATCH. acc_idle=0 -> stay, request stays pending.
//     LATCH: operand regs <= *_in (1 cycle) -> START.
//     START: acc_start=1; held until acc_ready sampled 1 -> WAIT (acc_start 0 next cycle);
//            if acc_done also 1 same cycle -> DONE.
//     WAIT : acc_done=1 -> DONE.
//     DONE : 1 cycle; dirc_valid=1 iff result captured this run; run_count+1 -> IDLE.
//   Latency: trigger sampled in IDLE at cycle T -> acc_start high from T+2.
//   Capture: in START/WAIT/DONE-entry, acc_next_dirc_vld=1 -> dirc_out<=acc_next_dirc, flag
//     captured; multiple vld in a run: last value wins. Run w/o vld: dirc_valid=0, dirc_out held.
//   Watchdog: cleared on LATCH, increments each cycle in START/WAIT; reaching TIMEOUT-1 ->
//     timeout_err=1, acc_start=0, -> IDLE (no DONE, run_count unchanged, dirc_out held).
//     Watchdog expiry and acc_done same cycle: acc_done wins.
//   err_clr: clears both sticky flags; coincident set event wins over clear.
//   Operands stable from LATCH until next LATCH; *_in changes mid-run ignored.
//   ap_rst mid-run: immediate return to reset values; core shares ap_rst, no resync needed.
// TESTING
//   sw_start pulse, core ready after 3 cyc, done+vld(0x5) after 10 -> acc_start 3 cyc, dirc_out=5, dirc_valid 1 pulse, run_count=1.
//   enable=1, PERIOD=20, core done in 5 -> one run every 20 cycles; 5 periods -> run_count=5, no errors.
//   acc_done never asserted, TIMEOUT=16 -> timeout_err=1 after 16 cyc in START/WAIT, busy=0; err_clr -> 0.
//   two sw_start pulses during a 30-cycle run -> second-run queued, third pulse sets overrun_err; exactly 2 runs total.
//   acc_idle=0 when trigger -> no LATCH until acc_idle=1; *_in changed during run -> acc_* ports unchanged.
//   ap_rst asserted in WAIT -> acc_start=0, busy=0, run_count=0 asynchronously; sw_start after release runs normally.

Source files
------------

// File: rtl/ap_seq_ctrl.sv
// Run sequencer for an ap_ctrl_hs HLS core: periodic/software triggers, operand latch,
// start/ready/done handshake, result capture, watchdog abort and overrun detection.
module ap_seq_ctrl #(
  parameter int unsigned PERIOD  = 1000,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned DW      = 32
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          enable,
  input  logic          sw_start,
  input  logic          err_clr,
  input  logic [DW-1:0] accel_x_in,
  input  logic [DW-1:0] yaw_in,
  input  logic [DW-1:0] start_point_in,
  input  logic [DW-1:0] end_point_in,
  output logic          acc_start,
  input  logic          acc_done,
  input  logic          acc_idle,
  input  logic          acc_ready,
  output logic [DW-1:0] acc_accel_x,
  output logic [DW-1:0] acc_yaw,
  output logic [DW-1:0] acc_start_point,
  output logic [DW-1:0] acc_end_point,
  input  logic [DW-1:0] acc_next_dirc,
  input  logic          acc_next_dirc_vld,
  output logic [DW-1:0] dirc_out,
  output logic          dirc_valid,
  output logic          busy,
  output logic          timeout_err,
  output logic          overrun_err,
  output logic [15:0]   run_count
);
  localparam int unsigned PW = (PERIOD  > 1) ? $clog2(PERIOD)  : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_START, S_WAIT, S_DONE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] per_cnt;
  logic [TW-1:0] wd_cnt;
  logic          pending;
  logic          captured;
  logic [DW-1:0] dirc_stage;
  logic          tick, trigger, wd_expire, in_hs, take, finish, abort;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state plus the transition qualifiers used by the datapath.
  always_comb begin
    tick      = enable && (per_cnt == PW'(PERIOD - 1));
    trigger   = tick || sw_start;
    in_hs     = (state == S_START) || (state == S_WAIT);
    wd_expire = (wd_cnt == TW'(TIMEOUT - 1));
    state_n   = state;
    case (state)
      S_IDLE:  if ((trigger || pending) && acc_idle) state_n = S_LATCH;
      S_LATCH: state_n = S_START;
      S_START: begin
        if (acc_ready && acc_done) state_n = S_DONE;
        else if (wd_expire)        state_n = S_IDLE;
        else if (acc_ready)        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (acc_done)       state_n = S_DONE;
        else if (wd_expire) state_n = S_IDLE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    take   = (state == S_IDLE) && (state_n == S_LATCH);
    finish = in_hs && (state_n == S_DONE);
    abort  = in_hs && (state_n == S_IDLE);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      per_cnt         <= '0;
      wd_cnt          <= '0;
      pending         <= 1'b0;
      captured        <= 1'b0;
      dirc_stage      <= '0;
      acc_start       <= 1'b0;
      busy            <= 1'b0;
      acc_accel_x     <= '0;
      acc_yaw         <= '0;
      acc_start_point <= '0;
      acc_end_point   <= '0;
      dirc_out        <= '0;
      dirc_valid      <= 1'b0;
      timeout_err     <= 1'b0;
      overrun_err     <= 1'b0;
      run_count       <= '0;
    end else begin
      per_cnt    <= (enable && !tick) ? per_cnt + PW'(1) : '0;
      acc_start  <= (state_n == S_START);
      busy       <= (state_n != S_IDLE);
      dirc_valid <= 1'b0;

      // At most one queued request; a trigger arriving on top of it is lost.
      if (take)         pending <= pending && trigger;
      else if (trigger) pending <= 1'b1;

      if (trigger && pending && !take) overrun_err <= 1'b1;
      else if (err_clr)                overrun_err <= 1'b0;

      if (abort)        timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      if (state == S_LATCH) begin
        acc_accel_x     <= accel_x_in;
        acc_yaw         <= yaw_in;
        acc_start_point <= start_point_in;
        acc_end_point   <= end_point_in;
        wd_cnt          <= '0;
        captured        <= 1'b0;
      end else if (in_hs) begin
        wd_cnt <= wd_cnt + TW'(1);
        if (acc_next_dirc_vld) begin
          captured   <= 1'b1;
          dirc_stage <= acc_next_dirc;
        end
      end

      // Result is staged during the run and published only when the run completes.
      if (finish) begin
        run_count <= run_count + 16'(1);
        if (captured || acc_next_dirc_vld) begin
          dirc_out   <= acc_next_dirc_vld ? acc_next_dirc : dirc_stage;
          dirc_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ap_seq_ctrl.sv
// Bench for ap_seq_ctrl: emulated HLS core, run-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ap_seq_ctrl;
  localparam int unsigned PERIOD  = 20;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned DW      = 32;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b0;
  logic          enable = 1'b0, sw_start = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] accel_x_in = '0, yaw_in = '0, start_point_in = '0, end_point_in = '0;
  logic          acc_done = 1'b0, acc_idle = 1'b1, acc_ready = 1'b0, acc_next_dirc_vld = 1'b0;
  logic [DW-1:0] acc_next_dirc = '0;
  logic          acc_start, dirc_valid, busy, timeout_err, overrun_err;
  logic [DW-1:0] acc_accel_x, acc_yaw, acc_start_point, acc_end_point, dirc_out;
  logic [15:0]   run_count;

  ap_seq_ctrl #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .DW(DW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .enable(enable), .sw_start(sw_start), .err_clr(err_clr),
    .accel_x_in(accel_x_in), .yaw_in(yaw_in), .start_point_in(start_point_in),
    .end_point_in(end_point_in), .acc_start(acc_start), .acc_done(acc_done),
    .acc_idle(acc_idle), .acc_ready(acc_ready), .acc_accel_x(acc_accel_x), .acc_yaw(acc_yaw),
    .acc_start_point(acc_start_point), .acc_end_point(acc_end_point),
    .acc_next_dirc(acc_next_dirc), .acc_next_dirc_vld(acc_next_dirc_vld),
    .dirc_out(dirc_out), .dirc_valid(dirc_valid), .busy(busy), .timeout_err(timeout_err),
    .overrun_err(overrun_err), .run_count(run_count)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a run is accepted at some cycle, latches one cycle later, then handshakes
  // with the elapsed handshake time bounding it; requests are counted, and more than one
  // outstanding is an overrun.
  logic          m_busy, m_start, m_dv, m_tmo, m_ovr;
  logic [DW-1:0] m_dirc, m_last;
  logic [DW-1:0] m_ops [4];
  logic [15:0]   m_rc;
  int            m_pcnt, m_req, m_el;
  bit            m_active, m_pdone, m_rdy, m_have;

  always @(posedge ap_clk or posedge ap_rst) begin : model
    bit tck, fin, tset, oset;
    int n;
    if (ap_rst) begin
      m_pcnt = 0; m_req = 0; m_el = 0;
      m_active = 0; m_pdone = 0; m_rdy = 0; m_have = 0;
      m_busy = 0; m_start = 0; m_dv = 0; m_tmo = 0; m_ovr = 0;
      m_dirc = '0; m_last = '0; m_rc = '0;
      for (int i = 0; i < 4; i++) m_ops[i] = '0;
    end else begin
      tset = 0; oset = 0; m_dv = 0;
      tck = enable && (m_pcnt == int'(PERIOD) - 1);
      m_pcnt = (!enable || tck) ? 0 : m_pcnt + 1;
      m_req += int'(tck || sw_start);
      if (m_pdone) begin
        m_pdone = 0;
        m_active = 0;
      end else if (!m_active) begin
        if (m_req > 0 && acc_idle) begin
          m_active = 1; m_el = 0; m_req--;
        end
      end else begin
        m_el++;
        if (m_el == 1) begin
          m_ops = '{accel_x_in, yaw_in, start_point_in, end_point_in};
          m_rdy = 0; m_have = 0;
        end else begin
          n = m_el - 2;
          if (acc_next_dirc_vld) begin m_have = 1; m_last = acc_next_dirc; end
          fin = acc_done && (m_rdy || acc_ready);
          if (fin) begin
            m_pdone = 1;
            m_rc = m_rc + 16'd1;
            if (m_have) begin m_dirc = m_last; m_dv = 1; end
          end else if (n == int'(TIMEOUT) - 1) begin
            m_active = 0; tset = 1;
          end else if (acc_ready) begin
            m_rdy = 1;
          end
        end
      end
      if (m_req > 1) begin m_req = 1; oset = 1; end
      m_tmo = tset ? 1'b1 : (err_clr ? 1'b0 : m_tmo);
      m_ovr = oset ? 1'b1 : (err_clr ? 1'b0 : m_ovr);
      m_busy  = m_active;
      m_start = m_active && !m_pdone && (m_el >= 1) && !m_rdy;
    end
  end

  // Emulated HLS core: ready after rdy_lat start cycles, done (+ optional result) after done_lat.
  bit            core_on = 0, rand_core = 0, give_vld = 1;
  int            core_k = 0, rdy_lat = 1, done_lat = 5, extra_at = -1;
  logic [DW-1:0] res_val = '0;
  int            start_total = 0, dv_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_now();
    chk("acc_start", 32'(acc_start), 32'(m_start));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("dirc_valid", 32'(dirc_valid), 32'(m_dv));
    chk("dirc_out", dirc_out, m_dirc);
    chk("timeout_err", 32'(timeout_err), 32'(m_tmo));
    chk("overrun_err", 32'(overrun_err), 32'(m_ovr));
    chk("run_count", 32'(run_count), 32'(m_rc));
    chk("acc_accel_x", acc_accel_x, m_ops[0]);
    chk("acc_yaw", acc_yaw, m_ops[1]);
    chk("acc_start_point", acc_start_point, m_ops[2]);
    chk("acc_end_point", acc_end_point, m_ops[3]);
    if (acc_start === 1'b1) start_total++;
    if (dirc_valid === 1'b1) dv_total++;
  endtask

  task automatic core_update();
    acc_ready = 0; acc_done = 0; acc_next_dirc_vld = 0;
    if (!busy) core_on = 0;
    if (acc_start && !core_on) begin
      core_on = 1; core_k = 0;
      if (rand_core) begin
        rdy_lat  = 1 + int'($urandom_range(0, 3));
        done_lat = ($urandom_range(0, 7) == 0) ? 0 : rdy_lat + int'($urandom_range(0, 9));
        give_vld = ($urandom_range(0, 3) != 0);
        res_val  = $urandom;
        extra_at = ($urandom_range(0, 2) == 0 && done_lat > 1) ?
                   int'($urandom_range(0, unsigned'(done_lat - 2))) : -1;
      end
    end
    if (core_on) begin
      if (core_k == rdy_lat - 1) acc_ready = 1;
      if (done_lat > 0 && core_k == done_lat - 1) begin
        acc_done = 1; acc_next_dirc_vld = give_vld; acc_next_dirc = res_val; core_on = 0;
      end else if (core_k == extra_at) begin
        acc_next_dirc_vld = 1; acc_next_dirc = $urandom;
      end
      core_k++;
    end
  endtask

  // One clock: core reacts to this cycle's acc_start, outputs are compared mid-cycle,
  // then the next cycle's inputs may be driven.
  task automatic cyc();
    core_update();
    @(negedge ap_clk);
    compare_now();
    #1;
    sw_start = 0; err_clr = 0;
  endtask

  task automatic do_reset();
    ap_rst = 1; enable = 0; sw_start = 0; err_clr = 0; acc_idle = 1;
    repeat (2) cyc();
    ap_rst = 0;
    cyc();
  endtask

  initial begin
    logic [DW-1:0] a_val [4];
    int s0, d0;
    #1;
    do_reset();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_run_count", 32'(run_count), 32'd0);
    chk("reset_dirc_out", dirc_out, 32'd0);

    // Single software run: ready on 3rd start cycle, done+result 0x5 after 10.
    rdy_lat = 3; done_lat = 10; give_vld = 1; res_val = 32'h5; extra_at = -1;
    s0 = start_total; d0 = dv_total;
    sw_start = 1; cyc();
    repeat (20) cyc();
    chk("t1_start_cycles", 32'(start_total - s0), 32'd3);
    chk("t1_dirc_out", dirc_out, 32'h5);
    chk("t1_dirc_valid_pulses", 32'(dv_total - d0), 32'd1);
    chk("t1_run_count", 32'(run_count), 32'd1);

    // Periodic auto-trigger over five periods.
    do_reset();
    rdy_lat = 1; done_lat = 5; res_val = 32'h1234;
    enable = 1;
    repeat (100) cyc();
    enable = 0;
    repeat (30) cyc();
    chk("t2_run_count", 32'(run_count), 32'd5);
    chk("t2_timeout_err", 32'(timeout_err), 32'd0);
    chk("t2_overrun_err", 32'(overrun_err), 32'd0);
    chk("t2_dirc_out", dirc_out, 32'h1234);

    // Watchdog: core never completes.
    do_reset();
    rdy_lat = 2; done_lat = 0;
    sw_start = 1; cyc();
    repeat (16) cyc();
    chk("t3_tmo_before", 32'(timeout_err), 32'd0);
    chk("t3_busy_before", 32'(busy), 32'd1);
    cyc();
    chk("t3_tmo_after", 32'(timeout_err), 32'd1);
    chk("t3_busy_after", 32'(busy), 32'd0);
    chk("t3_run_count", 32'(run_count), 32'd0);
    err_clr = 1; cyc();
    chk("t3_tmo_cleared", 32'(timeout_err), 32'd0);

    // Overrun: second trigger queues, third is lost.
    do_reset();
    rdy_lat = 2; done_lat = 12; res_val = 32'h7;
    sw_start = 1; cyc();
    repeat (5) cyc();
    sw_start = 1; cyc();
    repeat (3) cyc();
    sw_start = 1; cyc();
    repeat (60) cyc();
    chk("t4_overrun_err", 32'(overrun_err), 32'd1);
    chk("t4_run_count", 32'(run_count), 32'd2);
    chk("t4_timeout_err", 32'(timeout_err), 32'd0);
    err_clr = 1; cyc();
    chk("t4_ovr_cleared", 32'(overrun_err), 32'd0);

    // Core not idle holds the request; operands frozen after latch.
    do_reset();
    rdy_lat = 1; done_lat = 5; res_val = 32'h9;
    for (int i = 0; i < 4; i++) a_val[i] = $urandom;
    accel_x_in = a_val[0]; yaw_in = a_val[1]; start_point_in = a_val[2]; end_point_in = a_val[3];
    acc_idle = 0;
    sw_start = 1; cyc();
    repeat (8) cyc();
    chk("t5_busy_not_idle", 32'(busy), 32'd0);
    chk("t5_ops_untouched", acc_accel_x, 32'd0);
    acc_idle = 1;
    cyc(); cyc();
    accel_x_in = ~a_val[0]; yaw_in = ~a_val[1]; start_point_in = ~a_val[2]; end_point_in = ~a_val[3];
    repeat (15) cyc();
    chk("t5_accel_x", acc_accel_x, a_val[0]);
    chk("t5_yaw", acc_yaw, a_val[1]);
    chk("t5_start_point", acc_start_point, a_val[2]);
    chk("t5_end_point", acc_end_point, a_val[3]);
    chk("t5_run_count", 32'(run_count), 32'd1);

    // Reset asserted while waiting on the core.
    do_reset();
    rdy_lat = 1; done_lat = 5;
    sw_start = 1; cyc();
    repeat (12) cyc();
    done_lat = 0;
    sw_start = 1; cyc();
    repeat (5) cyc();
    chk("t6_busy_in_wait", 32'(busy), 32'd1);
    ap_rst = 1;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_start", 32'(acc_start), 32'd0);
    chk("t6_rst_run_count", 32'(run_count), 32'd0);
    cyc(); cyc();
    ap_rst = 0;
    cyc();
    done_lat = 5;
    sw_start = 1; cyc();
    repeat (12) cyc();
    chk("t6_after_run_count", 32'(run_count), 32'd1);
    chk("t6_after_busy", 32'(busy), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    rand_core = 1;
    repeat (3000) begin
      sw_start = ($urandom_range(0, 11) == 0);
      err_clr  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      acc_idle = ($urandom_range(0, 7) != 0);
      ap_rst   = ($urandom_range(0, 999) == 0);
      accel_x_in = $urandom; yaw_in = $urandom;
      start_point_in = $urandom; end_point_in = $urandom;
      cyc();
    end
    rand_core = 0; enable = 0; ap_rst = 0; acc_idle = 1; done_lat = 5; rdy_lat = 1; extra_at = -1;
    repeat (40) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
